// File: rtl/kc_aes_pkg.sv
// Shared AES types, GF(2^8) helpers and the MixColumns FSM encoding.
package kc_aes_pkg;

  localparam logic [7:0] AES_POLY = 8'h1B;

  typedef logic [7:0]   byte_t;
  typedef logic [31:0]  word_t;
  typedef logic [127:0] state_t;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} mc_state_e;

  function automatic byte_t xtime(input byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

  function automatic byte_t gmul2(input byte_t b);
    return xtime(b);
  endfunction

  function automatic byte_t gmul3(input byte_t b);
    return xtime(b) ^ b;
  endfunction

  // Inverse coefficients are sums of the x2/x4/x8 chain terms.
  function automatic byte_t gmul9(input byte_t b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic byte_t gmulb(input byte_t b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic byte_t gmuld(input byte_t b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic byte_t gmule(input byte_t b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

endpackage

// File: rtl/mix_column_word.sv
// One-column forward/inverse MixColumns, purely combinational.
module mix_column_word
  import kc_aes_pkg::*;
(
  input  word_t col,
  input  logic  inv,
  output word_t result
);

  byte_t a, b, c, d;

  assign {a, b, c, d} = col;

  always_comb begin
    if (inv) begin
      result = {gmule(a) ^ gmulb(b) ^ gmuld(c) ^ gmul9(d),
                gmul9(a) ^ gmule(b) ^ gmulb(c) ^ gmuld(d),
                gmuld(a) ^ gmul9(b) ^ gmule(c) ^ gmulb(d),
                gmulb(a) ^ gmuld(b) ^ gmul9(c) ^ gmule(d)};
    end else begin
      result = {gmul2(a) ^ gmul3(b) ^ c ^ d,
                a ^ gmul2(b) ^ gmul3(c) ^ d,
                a ^ b ^ gmul2(c) ^ gmul3(d),
                gmul3(a) ^ b ^ c ^ gmul2(d)};
    end
  end

endmodule

// File: rtl/mix_columns_iter.sv
// Iterative MixColumns/InvMixColumns stage: COLS_PER_CYCLE columns per BUSY cycle,
// result held in the state register until the downstream takes it.
module mix_columns_iter
  import kc_aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      in_valid_i,
  output logic      in_ready_o,
  input  state_t    state_i,
  input  logic      inv_i,
  input  logic      bypass_i,
  output logic      out_valid_o,
  input  logic      out_ready_i,
  output state_t    state_o,
  output logic      busy_o,
  output mc_state_e dbg_state
);

  localparam int NUM_GROUPS = 4 / COLS_PER_CYCLE;
  localparam int CNT_W      = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
    $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  mc_state_e        fsm_q;
  state_t           state_q;
  state_t           busy_next;
  logic             inv_q;
  logic [CNT_W-1:0] grp_q;
  logic             accept;
  logic             last_grp;
  word_t            col_in  [COLS_PER_CYCLE];
  word_t            col_out [COLS_PER_CYCLE];

  // Handshake: a transfer happens on any clock edge where valid and ready are both
  // high; valid, once raised, is held with stable data until that edge. in_ready_o
  // follows out_ready_i in DONE so a new block can replace the result with no bubble.
  assign in_ready_o  = (fsm_q == IDLE) || ((fsm_q == DONE) && out_ready_i);
  assign accept      = in_valid_i && in_ready_o;
  assign last_grp    = (grp_q == CNT_W'(NUM_GROUPS - 1));
  assign out_valid_o = (fsm_q == DONE);
  assign busy_o      = (fsm_q != IDLE);
  assign state_o     = state_q;
  assign dbg_state   = fsm_q;

  always_comb begin
    for (int k = 0; k < COLS_PER_CYCLE; k++) begin
      col_in[k] = state_q[127-32*k -: 32];
      for (int g = 1; g < NUM_GROUPS; g++) begin
        if (grp_q == CNT_W'(g)) col_in[k] = state_q[127-32*(g*COLS_PER_CYCLE+k) -: 32];
      end
    end
  end

  for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_col
    mix_column_word u_word (
      .col    (col_in[k]),
      .inv    (inv_q),
      .result (col_out[k])
    );
  end

  // Only the current group's columns change; the rest keep their latched bytes.
  always_comb begin
    busy_next = state_q;
    for (int c = 0; c < 4; c++) begin
      if (grp_q == CNT_W'(c / COLS_PER_CYCLE)) busy_next[127-32*c -: 32] = col_out[c % COLS_PER_CYCLE];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      inv_q   <= 1'b0;
      grp_q   <= '0;
    end else if (accept) begin
      state_q <= state_i;
      inv_q   <= inv_i;
      grp_q   <= '0;
      fsm_q   <= bypass_i ? DONE : BUSY;
    end else begin
      case (fsm_q)
        BUSY: begin
          state_q <= busy_next;
          grp_q   <= last_grp ? '0 : grp_q + CNT_W'(1);
          if (last_grp) fsm_q <= DONE;
        end
        DONE: begin
          if (out_ready_i) fsm_q <= IDLE;
        end
        default: ;
      endcase
    end
  end

endmodule
